// File: rtl/conv_encoder_framer.sv
// conv_encoder_framer
// Rate-1/2, K=4 (8-state) convolutional encoder with frame and tail control.
// Each frame is FRAME_LEN data bits followed by 3 zero tail bits, so the
// trellis starts and ends every frame in state 000.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   in_valid   in_bit is valid
//   in_ready   encoder accepts in_bit this cycle
//   in_bit     data bit
//   out_valid  d_out holds a symbol
//   out_ready  downstream accepts d_out this cycle
//   d_out      encoded symbol {G1 parity, G0 parity}
//   out_sof    symbol is the first of its frame
//   out_eof    symbol is the last tail symbol of its frame
//   busy       frame in progress (DATA or TAIL)
//
// state | meaning
// IDLE  | waiting for the first bit of a frame
// DATA  | accepting data bits 2..FRAME_LEN
// TAIL  | flushing 3 zero bits, no input accepted
module conv_encoder_framer #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter logic [3:0]  G0        = 4'b1111,
  parameter logic [3:0]  G1        = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] d_out,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t          state;
  logic [2:0]      s;
  logic [CW-1:0]   bit_cnt;
  logic [1:0]      tail_cnt;

  logic            slot_free;
  logic            b;
  logic [3:0]      r;
  logic [1:0]      sym;
  logic            step;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && (state != TAIL);
  assign b         = (state == TAIL) ? 1'b0 : in_bit;
  assign r         = {b, s};
  assign sym       = {^(r & G1), ^(r & G0)};
  // TAIL advances on its own whenever the output slot can take a symbol.
  assign step      = (state == TAIL) ? slot_free : (in_valid && in_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      s         <= 3'b000;
      bit_cnt   <= '0;
      tail_cnt  <= 2'd0;
      out_valid <= 1'b0;
      d_out     <= 2'b00;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (step) begin
      out_valid <= 1'b1;
      d_out     <= sym;
      s         <= {b, s[2:1]};
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      case (state)
        IDLE: begin
          out_sof  <= 1'b1;
          bit_cnt  <= CW'(1);
          tail_cnt <= 2'd0;
          if (FRAME_LEN == 1) state <= TAIL;
          else                state <= DATA;
        end
        DATA: begin
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_CNT) begin
            state    <= TAIL;
            tail_cnt <= 2'd0;
          end
        end
        TAIL: begin
          tail_cnt <= tail_cnt + 2'd1;
          if (tail_cnt == 2'd2) begin
            out_eof <= 1'b1;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
module tb_conv_encoder_framer;

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, out_ready;

  logic       rdy1, ov1, sof1, eof1, bsy1;
  logic [1:0] d1;
  logic       rdy4, ov4, sof4, eof4, bsy4;
  logic [1:0] d4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_encoder_framer #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_bit(in_bit),
    .out_valid(ov1), .out_ready(out_ready), .d_out(d1), .out_sof(sof1),
    .out_eof(eof1), .busy(bsy1)
  );

  conv_encoder_framer #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_bit(in_bit),
    .out_valid(ov4), .out_ready(out_ready), .d_out(d4), .out_sof(sof4),
    .out_eof(eof4), .busy(bsy4)
  );

  // One clock cycle: inputs, expected pre-edge in_ready (-1 = skip), and
  // expected registered outputs after the edge. sel 0 -> FRAME_LEN=1, 1 -> 4.
  typedef struct {
    string      tag;
    int         sel;
    bit         rst_n, iv, ib, ordy;
    int         er;
    bit         ov;
    logic [1:0] d;
    bit         sof, eof, bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(string tag, int sel, bit rst_n, bit iv, bit ib,
                               bit ordy, int er, bit ov, logic [1:0] d,
                               bit sof, bit eof, bit bsy);
    vec_t v;
    v.tag = tag; v.sel = sel; v.rst_n = rst_n; v.iv = iv; v.ib = ib;
    v.ordy = ordy; v.er = er; v.ov = ov; v.d = d; v.sof = sof; v.eof = eof;
    v.bsy = bsy;
    return v;
  endfunction

  task automatic check(string name, string tag, int idx, logic [1:0] act,
                       logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s cyc %0d: got %b expected %b", tag, name, idx, act, exp);
    end
  endtask

  // Entered just after a negedge; returns just after the next negedge.
  task automatic run_vec(vec_t v, int idx);
    logic       a_rdy, a_ov, a_sof, a_eof, a_bsy;
    logic [1:0] a_d;
    rst = v.rst_n; in_valid = v.iv; in_bit = v.ib; out_ready = v.ordy;
    #1;
    a_rdy = v.sel ? rdy4 : rdy1;
    if (v.er >= 0) check("in_ready", v.tag, idx, {1'b0, a_rdy}, v.er[1:0]);
    @(posedge clk);
    #1;
    a_ov  = v.sel ? ov4  : ov1;
    a_d   = v.sel ? d4   : d1;
    a_sof = v.sel ? sof4 : sof1;
    a_eof = v.sel ? eof4 : eof1;
    a_bsy = v.sel ? bsy4 : bsy1;
    check("out_valid", v.tag, idx, {1'b0, a_ov}, {1'b0, v.ov});
    check("busy", v.tag, idx, {1'b0, a_bsy}, {1'b0, v.bsy});
    if (v.ov || !v.rst_n) begin
      check("d_out", v.tag, idx, a_d, v.d);
      check("out_sof", v.tag, idx, {1'b0, a_sof}, {1'b0, v.sof});
      check("out_eof", v.tag, idx, {1'b0, a_eof}, {1'b0, v.eof});
    end
    @(negedge clk);
  endtask

  task automatic run_all_ones_head(string tag);
    run_vec(mkv(tag, 1, 0, 0, 0, 1, -1, 0, 2'b00, 0, 0, 0), 0);
    run_vec(mkv(tag, 1, 1, 1, 1, 1,  1, 1, 2'b11, 1, 0, 1), 1);
    run_vec(mkv(tag, 1, 1, 1, 1, 1,  1, 1, 2'b00, 0, 0, 1), 2);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;

    // Impulse, FRAME_LEN=1
    tbl.push_back(mkv("impulse", 0, 0, 0, 0, 1, -1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mkv("impulse", 0, 1, 1, 1, 1,  1, 1, 2'b11, 1, 0, 1));
    tbl.push_back(mkv("impulse", 0, 1, 1, 1, 1,  0, 1, 2'b11, 0, 0, 1));
    tbl.push_back(mkv("impulse", 0, 1, 1, 1, 1,  0, 1, 2'b01, 0, 0, 1));
    tbl.push_back(mkv("impulse", 0, 1, 1, 1, 1,  0, 1, 2'b11, 0, 1, 0));
    tbl.push_back(mkv("impulse", 0, 1, 0, 0, 1,  1, 0, 2'b00, 0, 0, 0));
    // Back-to-back, FRAME_LEN=1: bit 1 then bit 0
    tbl.push_back(mkv("b2b", 0, 0, 0, 0, 1, -1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mkv("b2b", 0, 1, 1, 1, 1,  1, 1, 2'b11, 1, 0, 1));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  0, 1, 2'b11, 0, 0, 1));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  0, 1, 2'b01, 0, 0, 1));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  0, 1, 2'b11, 0, 1, 0));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  1, 1, 2'b00, 1, 0, 1));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  0, 1, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  0, 1, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("b2b", 0, 1, 1, 0, 1,  0, 1, 2'b00, 0, 1, 0));
    tbl.push_back(mkv("b2b", 0, 1, 0, 0, 1,  1, 0, 2'b00, 0, 0, 0));
    // All-ones, FRAME_LEN=4
    tbl.push_back(mkv("ones", 1, 0, 0, 0, 1, -1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mkv("ones", 1, 1, 1, 1, 1,  1, 1, 2'b11, 1, 0, 1));
    tbl.push_back(mkv("ones", 1, 1, 1, 1, 1,  1, 1, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("ones", 1, 1, 1, 1, 1,  1, 1, 2'b01, 0, 0, 1));
    tbl.push_back(mkv("ones", 1, 1, 1, 1, 1,  1, 1, 2'b10, 0, 0, 1));
    tbl.push_back(mkv("ones", 1, 1, 0, 0, 1,  0, 1, 2'b01, 0, 0, 1));
    tbl.push_back(mkv("ones", 1, 1, 0, 0, 1,  0, 1, 2'b10, 0, 0, 1));
    tbl.push_back(mkv("ones", 1, 1, 0, 0, 1,  0, 1, 2'b11, 0, 1, 0));
    tbl.push_back(mkv("ones", 1, 1, 0, 0, 1,  1, 0, 2'b00, 0, 0, 0));
    // Input gaps, FRAME_LEN=4: bits 1,0,0,0 with in_valid toggling
    tbl.push_back(mkv("gaps", 1, 0, 0, 0, 1, -1, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mkv("gaps", 1, 1, 1, 1, 1,  1, 1, 2'b11, 1, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 0, 1, 1,  1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 1, 0, 1,  1, 1, 2'b11, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 0, 1, 1,  1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 1, 0, 1,  1, 1, 2'b01, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 0, 1, 1,  1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 1, 0, 1,  1, 1, 2'b11, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 0, 1, 1,  0, 1, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 0, 0, 1,  0, 1, 2'b00, 0, 0, 1));
    tbl.push_back(mkv("gaps", 1, 1, 0, 0, 1,  0, 1, 2'b00, 0, 1, 0));
    tbl.push_back(mkv("gaps", 1, 1, 0, 0, 1,  1, 0, 2'b00, 0, 0, 0));

    @(negedge clk);
    foreach (tbl[i]) run_vec(tbl[i], i);

    // Backpressure: hold off out_ready for 5 cycles after the 2nd symbol.
    run_all_ones_head("bp");
    for (int k = 0; k < 5; k++)
      run_vec(mkv("bp_stall", 1, 1, 1, 1, 0, 0, 1, 2'b00, 0, 0, 1), k);
    run_vec(mkv("bp", 1, 1, 1, 1, 1, 1, 1, 2'b01, 0, 0, 1), 3);
    run_vec(mkv("bp", 1, 1, 1, 1, 1, 1, 1, 2'b10, 0, 0, 1), 4);
    run_vec(mkv("bp", 1, 1, 0, 0, 1, 0, 1, 2'b01, 0, 0, 1), 5);
    run_vec(mkv("bp", 1, 1, 0, 0, 1, 0, 1, 2'b10, 0, 0, 1), 6);
    run_vec(mkv("bp", 1, 1, 0, 0, 1, 0, 1, 2'b11, 0, 1, 0), 7);
    run_vec(mkv("bp", 1, 1, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0), 8);

    // Reset during the 2nd tail symbol, then an impulse frame from s=000.
    run_all_ones_head("rst_tail");
    run_vec(mkv("rst_tail", 1, 1, 1, 1, 1,  1, 1, 2'b01, 0, 0, 1), 3);
    run_vec(mkv("rst_tail", 1, 1, 1, 1, 1,  1, 1, 2'b10, 0, 0, 1), 4);
    run_vec(mkv("rst_tail", 1, 1, 0, 0, 1,  0, 1, 2'b01, 0, 0, 1), 5);
    run_vec(mkv("rst_tail", 1, 0, 0, 0, 1,  0, 0, 2'b00, 0, 0, 0), 6);
    run_vec(mkv("rst_tail", 1, 1, 1, 1, 1,  1, 1, 2'b11, 1, 0, 1), 7);
    run_vec(mkv("rst_tail", 1, 1, 1, 0, 1,  1, 1, 2'b11, 0, 0, 1), 8);
    run_vec(mkv("rst_tail", 1, 1, 1, 0, 1,  1, 1, 2'b01, 0, 0, 1), 9);
    run_vec(mkv("rst_tail", 1, 1, 1, 0, 1,  1, 1, 2'b11, 0, 0, 1), 10);
    run_vec(mkv("rst_tail", 1, 1, 0, 0, 1,  0, 1, 2'b00, 0, 0, 1), 11);
    run_vec(mkv("rst_tail", 1, 1, 0, 0, 1,  0, 1, 2'b00, 0, 0, 1), 12);
    run_vec(mkv("rst_tail", 1, 1, 0, 0, 1,  0, 1, 2'b00, 0, 1, 0), 13);
    run_vec(mkv("rst_tail", 1, 1, 0, 0, 1,  1, 0, 2'b00, 0, 0, 0), 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_encoder_framer.md
Name: conv_encoder_framer

Overview:
- Rate-1/2, constraint-length-4 (8-state) convolutional encoder with frame and tail control.
- Produces the 2-bit symbol stream that the Viterbi decoder consumes on its d_in input.
- Accepts one data bit per handshake and emits one symbol per handshake.
- After FRAME_LEN data bits it appends 3 zero tail bits, so every frame starts and ends in trellis state 000, which is the state the decoder's path metrics reset to.

Parameters:
- FRAME_LEN, 1024: data bits per frame, legal range 1..65535. 1024 matches the decoder trellis memory bank depth.
- G0, 4'b1111: generator taps for d_out[0], applied to r = {in_bit, s[2], s[1], s[0]}.
- G1, 4'b1101: generator taps for d_out[1], applied to the same vector r.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  encoder accepts in_bit this cycle.
- in_bit  in  1  data bit.
- out_valid  out  1  d_out holds a symbol.
- out_ready  in  1  downstream accepts d_out this cycle.
- d_out  out  2  encoded symbol {G1 parity, G0 parity}.
- out_sof  out  1  current symbol is the first of its frame.
- out_eof  out  1  current symbol is the last tail symbol of its frame.
- busy  out  1  high while in state DATA or TAIL.

Behaviour:
- Reset: rst is sampled on the clk edge while low.
  - Outputs: out_valid=0, d_out=00, out_sof=0, out_eof=0, busy=0.
  - Internal: FSM=IDLE, shift state s=000, bit_cnt=0, tail_cnt=0.
  - Reset mid-frame discards the frame and any pending symbol; the next accepted bit starts a new frame.
- Encoding:
  - r = {b, s[2:0]}, where b is in_bit in IDLE/DATA and 0 in TAIL.
  - d_out[0] = XOR-reduce(r & G0); d_out[1] = XOR-reduce(r & G1).
  - Next state s <= {b, s[2:1]}; the new bit enters at the MSB.
- Output stage:
  - A single output register. slot_free = !out_valid || out_ready.
  - On a "step" (defined below) the output register loads the new symbol with out_valid=1. Otherwise, if out_ready=1, out_valid clears.
  - While out_valid=1 && out_ready=0, d_out, out_sof and out_eof stay stable.
  - Latency: a symbol is visible on d_out one cycle after its bit is accepted. Full throughput is 1 symbol per clk.
- in_ready = slot_free && (FSM==IDLE || FSM==DATA). in_ready is 0 throughout TAIL.
- FSM:
  - IDLE. Step when in_valid && in_ready. The symbol gets out_sof=1 and bit_cnt=1.
    - If FRAME_LEN==1, go to TAIL.
    - Otherwise go to DATA.
  - DATA. Step when in_valid && in_ready; bit_cnt increments.
    - The step that accepts bit number FRAME_LEN goes to TAIL with tail_cnt=0.
    - No timeout: the FSM waits in DATA indefinitely for in_valid.
  - TAIL. Step whenever slot_free, with b=0; tail_cnt increments.
    - The third tail step sets out_eof=1, resets bit_cnt, and goes to IDLE.
    - After three tail steps s is 000 by construction. s is not explicitly cleared.
- Back-to-back frames: the cycle after the third tail step, IDLE may accept the next frame's first bit if the slot is free. No bubble is required.
- out_sof and out_eof are never both 1 on the same symbol. The minimum frame is FRAME_LEN+3 symbols.
- busy = (FSM != IDLE).
- bit_cnt width is clog2(FRAME_LEN+1). No wrap occurs, because the FSM leaves DATA at FRAME_LEN.

Test Plan:
- Impulse, FRAME_LEN=1: in_bit=1 with out_ready=1 held high.
  - Required: symbols 11(sof), 11, 01, 11(eof), then busy=0.
  - in_ready=0 during the 3 tail cycles.
- All-ones, FRAME_LEN=4: bits 1,1,1,1.
  - Required: symbols 11(sof), 00, 01, 10, 01, 10, 11(eof).
- Backpressure, FRAME_LEN=4 with the all-ones frame: drop out_ready for 5 cycles after the 2nd symbol.
  - Required: d_out stays 00 with out_valid=1, in_ready=0.
  - Resume yields the identical 7-symbol sequence with no loss or duplication.
- Back-to-back, FRAME_LEN=1: two frames, bit 1 then bit 0, in_valid=1, out_ready=1 continuously.
  - Required: 11,11,01,11(eof), 00(sof),00,00,00(eof) on 8 consecutive cycles.
- Reset mid-TAIL, FRAME_LEN=4: pulse rst low for 1 cycle during the 2nd tail symbol.
  - Required: next cycle out_valid=0, busy=0.
  - A following impulse frame yields 11,11,01,11 + 3×00 tail, proving s=000.
- Input gaps, FRAME_LEN=4: in_valid toggles 1,0,1,0,... with bits 1,0,0,0.
  - Required: symbols 11(sof), 11, 01, 11, 00, 00, 00(eof).
  - busy stays 1 during the gaps, and out_valid clears in gap cycles.
